// File: rtl/riscv_defines.sv
// Shared RISC-V front-end definitions.
// Holds the default datapath width, the canonical NOP encoding
// (addi x0, x0, 0) and the fetch controller state encoding.
package riscv_defines;

  localparam int          WORD_WIDTH = 32;
  localparam logic [31:0] NOOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer for fetched {pc, instruction} pairs.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_i, data_i    write an entry at the tail (ignored when full or flushing)
//   pop_i             drop the head entry (ignored when empty or flushing)
//   flush_i           discard every entry; wins over push and pop
//   data_o            head entry (stale contents when empty)
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries
module fetch_fifo #(
  parameter int  WIDTH = 64,
  parameter int  DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !flush_i && !full_o;
  assign do_pop  = pop_i  && !flush_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; count decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: issues one memory request at a time,
// buffers returned words with their PC and hands the head entry to ID.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   fetch_en_i, pc_start_address_i      core enable and boot PC
//   instr_req_o, instr_addr_o           memory request and address
//   instr_gnt_i, instr_rvalid_i,
//   instr_rdata_i                       memory grant / response
//   branch_i, branch_target_i           redirect from the core
//   stall_i                             ID hazard stall (blocks pop)
//   instr_valid_o, instr_o,
//   instr_pc_o, instr_pc_plus4_o        head instruction towards ID
module instr_fetch_ctrl #(
  parameter int WORD_WIDTH = riscv_defines::WORD_WIDTH,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en_i,
  input  logic [WORD_WIDTH-1:0] pc_start_address_i,
  output logic                  instr_req_o,
  output logic [WORD_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [WORD_WIDTH-1:0] instr_rdata_i,
  input  logic                  branch_i,
  input  logic [WORD_WIDTH-1:0] branch_target_i,
  input  logic                  stall_i,
  output logic                  instr_valid_o,
  output logic [WORD_WIDTH-1:0] instr_o,
  output logic [WORD_WIDTH-1:0] instr_pc_o,
  output logic [WORD_WIDTH-1:0] instr_pc_plus4_o
);

  import riscv_defines::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e          state_q, state_d;
  logic [WORD_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  discard_q, discard_d;
  logic                  started_q, started_d;

  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic [CW-1:0]           count_next;
  logic                    room;
  logic [2*WORD_WIDTH-1:0] head;

  // Data is dropped when its transaction was redirected earlier or when the
  // redirect lands in the same cycle as the response.
  assign push = (state_q == WAIT) && instr_rvalid_i && !discard_q && !branch_i && !fifo_full;
  assign pop  = !fifo_empty && !stall_i && !branch_i;

  // Occupancy after this cycle's flush/push/pop, so a freed slot can be
  // refilled starting in the very next cycle.
  assign count_next = branch_i ? '0 : (fifo_count + CW'(push) - CW'(pop));
  assign room       = (count_next < CW'(FIFO_DEPTH));

  fetch_fifo #(
    .WIDTH (2*WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  ({req_pc_q, instr_rdata_i}),
    .pop_i   (pop),
    .flush_i (branch_i),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      req_pc_q   <= '0;
      discard_q  <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      discard_q  <= discard_d;
      started_q  <= started_d;
    end
  end

  // Next-state logic. A redirect during REQ cannot withdraw the request, so
  // it is marked for discard immediately; fetch_pc then already holds the
  // target and must not advance when that stale request is granted.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    discard_d  = discard_q;
    started_d  = started_q;

    case (state_q)
      IDLE: begin
        if (fetch_en_i && room) begin
          state_d = REQ;
          if (!started_q) begin
            fetch_pc_d = pc_start_address_i;
            started_d  = 1'b1;
          end
        end
      end
      REQ: begin
        if (branch_i) discard_d = 1'b1;
        if (instr_gnt_i) begin
          state_d = WAIT;
          if (!discard_q) fetch_pc_d = fetch_pc_q + WORD_WIDTH'(4);
        end
      end
      WAIT: begin
        if (instr_rvalid_i) begin
          discard_d = 1'b0;
          if (!fetch_en_i) state_d = IDLE;
          else if (room)   state_d = REQ;
          else             state_d = HOLD;
        end else if (branch_i) begin
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        if (!fetch_en_i) state_d = IDLE;
        else if (room)   state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (branch_i) begin
      fetch_pc_d = branch_target_i;
      started_d  = 1'b1;
    end

    // req_pc doubles as the address register: captured on entry to REQ and
    // held through the grant, so it is the issued address during WAIT.
    if ((state_q != REQ) && (state_d == REQ)) req_pc_d = fetch_pc_d;
  end

  assign instr_req_o      = (state_q == REQ);
  assign instr_addr_o     = req_pc_q;
  assign instr_valid_o    = !fifo_empty;
  assign instr_o          = fifo_empty ? WORD_WIDTH'(NOOP_INSTR) : head[WORD_WIDTH-1:0];
  assign instr_pc_o       = fifo_empty ? '0 : head[2*WORD_WIDTH-1:WORD_WIDTH];
  assign instr_pc_plus4_o = instr_pc_o + WORD_WIDTH'(4);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Testbench for instr_fetch_ctrl: directed scenarios followed by random
// traffic, compared every cycle against a transaction-level model.
module tb_instr_fetch_ctrl;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOOP  = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en_i = 1'b0;
  logic [31:0] pc_start_address_i = '0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        stall_i = 1'b0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] instr_pc_plus4_o;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Reference model: buffered entries, the next PC to fetch, whether a
  // request is being presented, whether one is in flight, and whether the
  // in-flight response must be thrown away.
  entry_t      mq[$];
  logic [31:0] mNextPc;
  logic [31:0] mReqAddr;
  logic [31:0] mOutAddr;
  bit          mReqActive;
  bit          mOutstanding;
  bit          mDropNext;
  bit          mBooted;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(
    .WORD_WIDTH (32),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fetch_en_i         (fetch_en_i),
    .pc_start_address_i (pc_start_address_i),
    .instr_req_o        (instr_req_o),
    .instr_addr_o       (instr_addr_o),
    .instr_gnt_i        (instr_gnt_i),
    .instr_rvalid_i     (instr_rvalid_i),
    .instr_rdata_i      (instr_rdata_i),
    .branch_i           (branch_i),
    .branch_target_i    (branch_target_i),
    .stall_i            (stall_i),
    .instr_valid_o      (instr_valid_o),
    .instr_o            (instr_o),
    .instr_pc_o         (instr_pc_o),
    .instr_pc_plus4_o   (instr_pc_plus4_o)
  );

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    mq.delete();
    mNextPc      = '0;
    mReqAddr     = '0;
    mOutAddr     = '0;
    mReqActive   = 1'b0;
    mOutstanding = 1'b0;
    mDropNext    = 1'b0;
    mBooted      = 1'b0;
  endfunction

  // One clock of the model, from the rules of the fetch protocol.
  function automatic void modelStep(input bit fen, input bit gnt, input bit rv,
                                    input logic [31:0] rdata, input bit br,
                                    input logic [31:0] tgt, input bit st);
    bit     popNow = (mq.size() != 0) && !st && !br;
    bit     havePush = 1'b0;
    entry_t e;
    e.pc = '0;
    e.instr = '0;
    if (mOutstanding) begin
      if (rv) begin
        if (!mDropNext && !br) begin
          havePush = 1'b1;
          e.pc     = mOutAddr;
          e.instr  = rdata;
        end
        mDropNext    = 1'b0;
        mOutstanding = 1'b0;
      end else if (br) begin
        mDropNext = 1'b1;
      end
    end else if (mReqActive) begin
      if (br) mDropNext = 1'b1;
      if (gnt) begin
        mReqActive   = 1'b0;
        mOutstanding = 1'b1;
        mOutAddr     = mReqAddr;
        if (!mDropNext) mNextPc = mReqAddr + 32'd4;
      end
    end
    if (br) begin
      mNextPc = tgt;
      mBooted = 1'b1;
      mq.delete();
    end else begin
      if (popNow) void'(mq.pop_front());
      if (havePush) mq.push_back(e);
    end
    if (!mReqActive && !mOutstanding && fen && (mq.size() < DEPTH)) begin
      if (!mBooted) begin
        mNextPc = pc_start_address_i;
        mBooted = 1'b1;
      end
      mReqActive = 1'b1;
      mReqAddr   = mNextPc;
    end
  endfunction

  task automatic checkOutput();
    expectEq("instr_req", 32'(instr_req_o), 32'(mReqActive));
    if (mReqActive) expectEq("instr_addr", instr_addr_o, mReqAddr);
    expectEq("instr_valid", 32'(instr_valid_o), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      expectEq("instr", instr_o, mq[0].instr);
      expectEq("instr_pc", instr_pc_o, mq[0].pc);
      expectEq("instr_pc_plus4", instr_pc_plus4_o, mq[0].pc + 32'd4);
    end else begin
      expectEq("instr_noop", instr_o, NOOP);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, and
  // check the registered outputs at the next falling edge.
  task automatic applyStimulus(input bit fen, input bit gnt, input bit rv,
                               input logic [31:0] rdata, input bit br,
                               input logic [31:0] tgt, input bit st);
    fetch_en_i      = fen;
    instr_gnt_i     = gnt;
    instr_rvalid_i  = rv;
    instr_rdata_i   = rdata;
    branch_i        = br;
    branch_target_i = tgt;
    stall_i         = st;
    modelStep(fen, gnt, rv, rdata, br, tgt, st);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic doReset();
    rst_n          = 1'b0;
    fetch_en_i     = 1'b0;
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b0;
    branch_i       = 1'b0;
    stall_i        = 1'b0;
    modelReset();
    @(negedge clk);
    expectEq("rst_req", 32'(instr_req_o), 32'd0);
    expectEq("rst_addr", instr_addr_o, 32'd0);
    expectEq("rst_valid", 32'(instr_valid_o), 32'd0);
    expectEq("rst_instr", instr_o, NOOP);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit fen, gnt, rv, br, st;
    logic [31:0] tgt;
    int guard;

    pc_start_address_i = 32'h80;
    doReset();

    // Boot fetch with grant and response one cycle apart each.
    applyStimulus(1, 0, 0, '0, 0, '0, 0);
    expectEq("boot_addr", instr_addr_o, 32'h80);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 0, '0, 0, '0, 0);
      expectEq("valid_before_rvalid", 32'(instr_valid_o), 32'd0);
      applyStimulus(1, 0, 1, 32'h1000_0000 + 32'(k), 0, '0, 0);
      expectEq("valid_after_rvalid", 32'(instr_valid_o), 32'd1);
      expectEq("seq_addr", instr_addr_o, 32'h80 + 32'(4 * (k + 1)));
    end

    // Grant withheld: request and address must stay put.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 0, 0, '0, 0, '0, 0);
      expectEq("gnt_wait_addr", instr_addr_o, 32'h8C);
    end
    applyStimulus(1, 1, 0, '0, 0, '0, 0);
    applyStimulus(1, 0, 1, 32'h2000_0000, 0, '0, 0);

    // Stalled ID fills the buffer, then fetching pauses.
    guard = 0;
    while ((mReqActive || mOutstanding) && guard < 20) begin
      applyStimulus(1, 1, 0, '0, 0, '0, 1);
      applyStimulus(1, 0, 1, $urandom, 0, '0, 1);
      guard++;
    end
    expectEq("fill_bound", 32'(guard < 20), 32'd1);
    expectEq("full_count", 32'(mq.size()), 32'(DEPTH));
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 0, '0, 0, '0, 1);
      expectEq("hold_noreq", 32'(instr_req_o), 32'd0);
    end
    applyStimulus(1, 0, 0, '0, 0, '0, 0);
    expectEq("hold_to_req", 32'(instr_req_o), 32'd1);

    // Redirect while waiting for the response.
    applyStimulus(1, 1, 0, '0, 0, '0, 0);
    applyStimulus(1, 0, 0, '0, 1, 32'h200, 0);
    applyStimulus(1, 0, 1, 32'hDEAD_BEEF, 0, '0, 0);
    expectEq("br_wait_valid", 32'(instr_valid_o), 32'd0);
    expectEq("br_wait_addr", instr_addr_o, 32'h200);

    // Redirect coincident with the response while the buffer holds data.
    applyStimulus(1, 1, 0, '0, 0, '0, 1);
    applyStimulus(1, 0, 1, 32'hAAAA_0001, 0, '0, 1);
    applyStimulus(1, 1, 0, '0, 0, '0, 1);
    applyStimulus(1, 0, 1, 32'hAAAA_0002, 1, 32'h300, 1);
    expectEq("br_rv_valid", 32'(instr_valid_o), 32'd0);
    expectEq("br_rv_instr", instr_o, NOOP);

    // Redirect to the top of the address space wraps to zero.
    applyStimulus(1, 0, 0, '0, 1, 32'hFFFF_FFFC, 0);
    applyStimulus(1, 1, 0, '0, 0, '0, 0);
    applyStimulus(1, 0, 1, 32'h5555_5555, 0, '0, 0);
    expectEq("wrap_pre_addr", instr_addr_o, 32'hFFFF_FFFC);
    applyStimulus(1, 1, 0, '0, 0, '0, 1);
    applyStimulus(1, 0, 1, 32'h6666_6666, 0, '0, 1);
    expectEq("wrap_addr", instr_addr_o, 32'h0000_0000);
    expectEq("wrap_pc_plus4", instr_pc_plus4_o, 32'h0000_0000);

    // Reset with a transaction in flight; the late response is ignored.
    applyStimulus(1, 1, 0, '0, 0, '0, 0);
    pc_start_address_i = 32'h1000;
    doReset();
    applyStimulus(0, 0, 1, 32'h7777_7777, 0, '0, 0);
    expectEq("late_rvalid_valid", 32'(instr_valid_o), 32'd0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      fen = ($urandom_range(0, 15) != 0);
      gnt = ($urandom_range(0, 2) != 0);
      rv  = mOutstanding ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      br  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      st  = ($urandom_range(0, 3) == 0);
      if (i == 750) doReset();
      applyStimulus(fen, gnt, rv, $urandom, br, tgt, st);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
